shared_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit state register among N_REQ requesters.
- Each requester writes via a valid/ready handshake and may request a byte-lane swap on write: low byte goes to the high lane, high byte to the low lane.
- Supports multi-cycle ownership (lock) so one requester can issue back-to-back writes without interleaving.
- Sits between producer blocks and the shared register source/sink pair; the registered value drives all consumers.

---
 rtl/shared_reg_arbiter_if.sv | 51 +++++
 rtl/shared_reg_arbiter.sv | 150 +++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter_if
// Bundles the requester-facing write handshake and the shared register output
// of shared_reg_arbiter.
//   master : producer side (drives requests, sees grants and the shared value)
//   slave  : arbiter side
// Signals:
//   req_valid / req_data / req_swap / req_lock : per-requester write request
//   req_ready : one-hot (or zero) grant, combinational
//   wr_fire   : a write commits this cycle
//   grant_id  : index of the current winner, 0 when nothing is granted
//   out       : registered shared value
// Optional (SHARED_REG_ARB_STATS_EN): stall_clear input, stall_count output.
// -----------------------------------------------------------------------------
interface shared_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_swap;
    logic [N_REQ-1:0]       req_lock;
    logic [N_REQ-1:0]       req_ready;
    logic                   wr_fire;
    logic [ID_W-1:0]        grant_id;
    logic [WIDTH-1:0]       out;
`ifdef SHARED_REG_ARB_STATS_EN
    logic                   stall_clear;
    logic [7:0]             stall_count;
`endif

    modport master (
        output req_valid, req_data, req_swap, req_lock,
`ifdef SHARED_REG_ARB_STATS_EN
        output stall_clear,
        input  stall_count,
`endif
        input  req_ready, wr_fire, grant_id, out
    );

    modport slave (
        input  req_valid, req_data, req_swap, req_lock,
`ifdef SHARED_REG_ARB_STATS_EN
        input  stall_clear,
        output stall_count,
`endif
        output req_ready, wr_fire, grant_id, out
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// A granted requester may swap the upper and lower halves of its data on
// write, and may hold the register (lock) for back-to-back writes.
// Ports:
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset
//   bus        : shared_reg_arbiter_if.slave (requests, grant, shared value)
// Optional feature macro: SHARED_REG_ARB_STATS_EN adds a saturating 8-bit
// stall counter (bus.stall_count) with a synchronous clear (bus.stall_clear).
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
    parameter int               N_REQ = 4,
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input logic                   CLK,
    input logic                   ASYNCRESET,
    shared_reg_arbiter_if.slave   bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HALF = WIDTH / 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]       state_r;
    logic [ID_W-1:0]  owner_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [WIDTH-1:0] out_r;

    logic [N_REQ-1:0] ready_s;
    logic [ID_W-1:0]  win_s;
    logic             found_s;
    logic             fire_s;
    logic [WIDTH-1:0] data_s;
    int               idx_s;

    // Exchange the upper and lower halves of a data word.
    function automatic logic [WIDTH-1:0] swap_lanes(input logic [WIDTH-1:0] d);
        return {d[HALF-1:0], d[WIDTH-1:HALF]};
    endfunction

    // Successor index modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        if (int'(i) >= N_REQ - 1) begin
            return {ID_W{1'b0}};
        end else begin
            return i + {{(ID_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Grant selection: owner only while OWNED, else first valid from rr_ptr.
    always_comb begin
        ready_s = {N_REQ{1'b0}};
        win_s   = {ID_W{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        if (ASYNCRESET) begin
            // No grant may be visible while reset is held.
            found_s = 1'b0;
        end else if (state_r == ST_OWNED) begin
            win_s            = owner_r;
            found_s          = bus.req_valid[owner_r];
            ready_s[owner_r] = bus.req_valid[owner_r];
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx_s = int'(rr_ptr_r) + k;
                if (idx_s >= N_REQ) begin
                    idx_s = idx_s - N_REQ;
                end else begin
                    idx_s = idx_s;
                end
                if (!found_s && bus.req_valid[idx_s]) begin
                    found_s = 1'b1;
                    win_s   = idx_s[ID_W-1:0];
                end else begin
                    found_s = found_s;
                end
            end
            if (found_s) begin
                ready_s[win_s] = 1'b1;
            end else begin
                ready_s = {N_REQ{1'b0}};
            end
        end
    end

    assign fire_s       = |(bus.req_valid & ready_s);
    assign data_s       = bus.req_data[int'(win_s)*WIDTH +: WIDTH];
    assign bus.req_ready = ready_s;
    assign bus.wr_fire   = fire_s;
    assign bus.grant_id  = found_s ? win_s : {ID_W{1'b0}};
    assign bus.out       = out_r;

    // Shared register, round-robin pointer and ownership state.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            out_r    <= INIT;
            rr_ptr_r <= {ID_W{1'b0}};
            state_r  <= ST_IDLE;
            owner_r  <= {ID_W{1'b0}};
        end else begin
            if (fire_s) begin
                out_r <= bus.req_swap[win_s] ? swap_lanes(data_s) : data_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (fire_s) begin
                        rr_ptr_r <= next_idx(win_s);
                        if (bus.req_lock[win_s]) begin
                            state_r <= ST_OWNED;
                            owner_r <= win_s;
                        end
                    end
                end
                ST_OWNED: begin
                    // Releasing lock ends ownership even without a write.
                    if (!bus.req_lock[owner_r]) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_idx(owner_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHARED_REG_ARB_STATS_EN
    logic [7:0] stall_count_r;
    logic       stall_s;

    assign stall_s         = |(bus.req_valid & ~ready_s);
    assign bus.stall_count = stall_count_r;

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            stall_count_r <= 8'd0;
        end else if (bus.stall_clear) begin
            stall_count_r <= 8'd0;
        end else if (stall_s && (stall_count_r != 8'hFF)) begin
            stall_count_r <= stall_count_r + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Directed stimulus for shared_reg_arbiter (N_REQ=4, WIDTH=16, INIT=0).
// Each write the stimulus expects pushes its grant and resulting register
// value into queues; a negedge monitor pops and compares whenever the DUT
// reports wr_fire, and checks the register one cycle later.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;
    logic CLK;
    logic ASYNCRESET;

    shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus ();

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(16), .INIT(16'h0000)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  exp_ready[$];
    logic [1:0]  exp_id[$];
    logic [15:0] exp_out[$];
    logic        pend_out = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] rdy, input logic [1:0] id, input logic [15:0] val);
        exp_ready.push_back(rdy);
        exp_id.push_back(id);
        exp_out.push_back(val);
    endtask

    task automatic set_d(input int i, input logic [15:0] v);
        bus.req_data[i*16 +: 16] = v;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (pend_out) begin
            if (exp_out.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_queue: no expected value for out=%h", bus.out);
            end else begin
                check("out", {16'h0000, bus.out}, {16'h0000, exp_out.pop_front()});
            end
        end
        pend_out = 1'b0;
        if (bus.wr_fire === 1'b1) begin
            if (exp_ready.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fire: got ready=%b expected no write", bus.req_ready);
            end else begin
                check("grant_ready", {28'h0, bus.req_ready}, {28'h0, exp_ready.pop_front()});
                check("grant_id", {30'h0, bus.grant_id}, {30'h0, exp_id.pop_front()});
                pend_out = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ASYNCRESET    = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = 64'h0;
        bus.req_swap  = 4'h0;
        bus.req_lock  = 4'h0;
`ifdef SHARED_REG_ARB_STATS_EN
        bus.stall_clear = 1'b0;
`endif
        #3;
        check("rst_out", {16'h0, bus.out}, 32'h0);
        check("rst_ready", {28'h0, bus.req_ready}, 32'h0);
        check("rst_fire", {31'h0, bus.wr_fire}, 32'h0);
        bus.req_valid = 4'h0;
        @(posedge CLK);
        @(posedge CLK);
        #2 ASYNCRESET = 1'b0;

        // Idle: nothing granted, register holds INIT
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_out", {16'h0, bus.out}, 32'h0);
            check("idle_ready", {28'h0, bus.req_ready}, 32'h0);
            check("idle_fire", {31'h0, bus.wr_fire}, 32'h0);
            check("idle_id", {30'h0, bus.grant_id}, 32'h0);
        end
        step();

        // Requester 1, no swap
        bus.req_valid = 4'b0010; set_d(1, 16'h12AB);
        expect_write(4'b0010, 2'd1, 16'h12AB);
        step();
        // Requester 2, swap
        bus.req_valid = 4'b0100; set_d(2, 16'h12AB); bus.req_swap = 4'b0100;
        expect_write(4'b0100, 2'd2, 16'hAB12);
        step();
        // Requester 3, swap of equal bytes leaves value unchanged
        bus.req_valid = 4'b1000; set_d(3, 16'h5A5A); bus.req_swap = 4'b1000;
        expect_write(4'b1000, 2'd3, 16'h5A5A);
        step();

        // All valid from rr_ptr=0: grants 0,1,2,3,0
        bus.req_swap = 4'b0000; bus.req_valid = 4'b1111;
        set_d(0, 16'h1111); set_d(1, 16'h2222); set_d(2, 16'h3333); set_d(3, 16'h4444);
        expect_write(4'b0001, 2'd0, 16'h1111);
        expect_write(4'b0010, 2'd1, 16'h2222);
        expect_write(4'b0100, 2'd2, 16'h3333);
        expect_write(4'b1000, 2'd3, 16'h4444);
        expect_write(4'b0001, 2'd0, 16'h1111);
        repeat (5) step();

        // Lock: requester 3 owns, requester 0 stalled
        bus.req_valid = 4'b1000; bus.req_lock = 4'b1000; set_d(3, 16'h00FF);
        expect_write(4'b1000, 2'd3, 16'h00FF);
        step();
        bus.req_valid = 4'b1001; set_d(0, 16'h0A0A); set_d(3, 16'h0001);
        expect_write(4'b1000, 2'd3, 16'h0001);
        step();
        set_d(3, 16'h0002);
        expect_write(4'b1000, 2'd3, 16'h0002);
        step();
        bus.req_valid = 4'b0001; bus.req_lock = 4'b0000;
        #1;
        check("exit_no_grant", {28'h0, bus.req_ready}, 32'h0);
        step();
        expect_write(4'b0001, 2'd0, 16'h0A0A);
        step();

        // Lock released in a cycle that also writes; the write commits
        bus.req_valid = 4'b0100; bus.req_lock = 4'b0100; set_d(2, 16'h0BB0);
        expect_write(4'b0100, 2'd2, 16'h0BB0);
        step();
        bus.req_valid = 4'b0110; bus.req_lock = 4'b0000; set_d(2, 16'h0CC0); set_d(1, 16'h0D0D);
        expect_write(4'b0100, 2'd2, 16'h0CC0);
        step();
        bus.req_valid = 4'b0011; set_d(0, 16'h0E0E);
        expect_write(4'b0001, 2'd0, 16'h0E0E);
        step();
        bus.req_valid = 4'b0010;
        expect_write(4'b0010, 2'd1, 16'h0D0D);
        step();

        // Async reset while OWNED
        bus.req_valid = 4'b0010; bus.req_lock = 4'b0010; set_d(1, 16'h7777);
        expect_write(4'b0010, 2'd1, 16'h7777);
        step();
        bus.req_valid = 4'b0000;
        step();
        bus.req_valid = 4'b0011; set_d(0, 16'h0F0F);
        #1 ASYNCRESET = 1'b1;
        #1;
        check("amid_out", {16'h0, bus.out}, 32'h0);
        check("amid_ready", {28'h0, bus.req_ready}, 32'h0);
        check("amid_fire", {31'h0, bus.wr_fire}, 32'h0);
        bus.req_lock = 4'b0000;
        expect_write(4'b0001, 2'd0, 16'h0F0F);
        @(posedge CLK);
        #3 ASYNCRESET = 1'b0;
        @(posedge CLK);
        #1;

`ifdef SHARED_REG_ARB_STATS_EN
        // Two-requester contention: one stalled every cycle
        bus.req_valid = 4'b0011; set_d(0, 16'h0101); set_d(1, 16'h0202);
        for (int k = 0; k < 300; k++) begin
            if ((k % 2) == 0) expect_write(4'b0010, 2'd1, 16'h0202);
            else              expect_write(4'b0001, 2'd0, 16'h0101);
            step();
        end
        check("stall_sat", {24'h0, bus.stall_count}, 32'd255);
        bus.stall_clear = 1'b1;
        expect_write(4'b0010, 2'd1, 16'h0202);
        step();
        bus.stall_clear = 1'b0;
        check("stall_clear", {24'h0, bus.stall_count}, 32'd0);
`endif

        bus.req_valid = 4'b0000;
        repeat (3) step();
        check("queue_drained", exp_ready.size(), 32'd0);
        check("out_drained", exp_out.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
